// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and status bundle for alu_issue_ctrl.
// slave is the controller side, master is the upstream/ALU/observer side.
interface alu_issue_ctrl_if;
  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // the upstream holds cmd_valid and the command fields stable until that edge,
  // and cmd_ready never depends on cmd_valid.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_a;
  logic [1:0] cmd_src_b;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;

  logic [7:0] alu_A;
  logic [7:0] alu_B;
  logic [7:0] alu_Selector;
  logic [7:0] alu_X;
  logic [7:0] alu_Flags;

  logic [7:0] flags_q;
  logic       done;
  logic       err;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    input  alu_X, alu_Flags, rd_sel,
    output cmd_ready, alu_A, alu_B, alu_Selector, flags_q, done, err, rd_data
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    output alu_X, alu_Flags, rd_sel,
    input  cmd_ready, alu_A, alu_B, alu_Selector, flags_q, done, err, rd_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational 8-bit ALU: latches a command,
// drives the ALU for one cycle, commits result/flags to a 4x8 register file.
module alu_issue_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_ctrl_if.slave      bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] OP_DIV = 8'h04;
  localparam logic [7:0] OP_REM = 8'h05;
  localparam logic [7:0] OP_CMP = 8'h0F;
  localparam logic [7:0] OP_MOV = 8'h80;

  state_e          state_q, state_d;
  logic [3:0][7:0] rf_q, rf_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [1:0]      dst_q, dst_d;
  logic [7:0]      flags_q, flags_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  logic            op_legal;
  logic            div_zero;
  logic            reject;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  // The latched op/operand registers are the ALU drive registers: loaded on
  // accept, cleared when ISSUE ends, so the ALU inputs read 0x00 outside ISSUE.
  assign bus.alu_Selector = op_q;
  assign bus.alu_A        = a_q;
  assign bus.alu_B        = b_q;
  assign bus.flags_q      = flags_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rd_data      = rf_q[bus.rd_sel];
  assign dbg_state        = state_q;

  assign op_legal = ((op_q >= 8'h01) && (op_q <= 8'h0F)) || (op_q == OP_MOV);
  assign div_zero = ((op_q == OP_DIV) || (op_q == OP_REM)) && (b_q == 8'h00);
  assign reject   = !op_legal || div_zero;

  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          dst_d   = bus.cmd_dst;
          a_d     = rf_q[bus.cmd_src_a];
          b_d     = bus.cmd_use_imm ? bus.cmd_imm : rf_q[bus.cmd_src_b];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!reject) begin
          flags_d = bus.alu_Flags;
          // Compare only sets flags; its ALU result is discarded.
          if (op_q != OP_CMP) begin
            rf_d[dst_q] = bus.alu_X;
          end
        end
        err_d   = reject;
        done_d  = 1'b1;
        op_d    = 8'h00;
        a_d     = 8'h00;
        b_d     = 8'h00;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rf_q    <= '0;
      op_q    <= 8'h00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      dst_q   <= 2'd0;
      flags_q <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a small ALU model, a vector table of
// commands with hand-computed results, and sequences for backpressure and reset abort.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // External ALU model. Flags: [6]=overflow, [2]=sign, [0]=zero, others 0.
  logic [7:0] m_x;
  logic       m_ovf;
  always_comb begin
    m_ovf = 1'b0;
    case (bus.alu_Selector)
      8'h01: begin
        m_x   = bus.alu_A + bus.alu_B;
        m_ovf = (bus.alu_A[7] == bus.alu_B[7]) && (m_x[7] != bus.alu_A[7]);
      end
      8'h02, 8'h0F: begin
        m_x   = bus.alu_A - bus.alu_B;
        m_ovf = (bus.alu_A[7] != bus.alu_B[7]) && (m_x[7] != bus.alu_A[7]);
      end
      8'h04:   m_x = (bus.alu_B == 8'h00) ? 8'hFF : bus.alu_A / bus.alu_B;
      8'h05:   m_x = (bus.alu_B == 8'h00) ? 8'hFF : bus.alu_A % bus.alu_B;
      8'h80:   m_x = bus.alu_B;
      default: m_x = bus.alu_A ^ bus.alu_B;
    endcase
    bus.alu_X     = m_x;
    bus.alu_Flags = {1'b0, m_ovf, 3'b000, m_x[7], 1'b0, (m_x == 8'h00)};
  end

  typedef struct {
    logic [7:0] op;
    logic [1:0] dst;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       use_imm;
    logic [7:0] imm;
    logic [7:0] exp_dst;
    logic [7:0] exp_flags;
    logic       exp_err;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [1:0] dst, input logic [1:0] sa,
                              input logic [1:0] sb, input logic use_imm, input logic [7:0] imm,
                              input logic [7:0] exp_dst, input logic [7:0] exp_flags,
                              input logic exp_err);
    vec_t v;
    v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.use_imm = use_imm; v.imm = imm;
    v.exp_dst = exp_dst; v.exp_flags = exp_flags; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.cmd_op      = v.op;
    bus.cmd_dst     = v.dst;
    bus.cmd_src_a   = v.sa;
    bus.cmd_src_b   = v.sb;
    bus.cmd_use_imm = v.use_imm;
    bus.cmd_imm     = v.imm;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s ready", name), {7'd0, bus.cmd_ready}, 8'h01);
  endtask

  // One command end to end: accept, ISSUE, DONE, back in IDLE, then result readback.
  task automatic run_cmd(input vec_t v, input string name);
    logic [7:0] e;
    e = exp_q.pop_front();
    @(negedge clk);
    drive(v);
    bus.cmd_valid = 1'b1;
    wait_ready(name);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check($sformatf("%s issue sel", name), bus.alu_Selector, v.op);
    check($sformatf("%s issue done", name), {7'd0, bus.done}, 8'h00);
    if (v.use_imm) check($sformatf("%s issue alu_B", name), bus.alu_B, v.imm);
    @(posedge clk);
    #1;
    check($sformatf("%s done", name), {7'd0, bus.done}, 8'h01);
    check($sformatf("%s err", name), {7'd0, bus.err}, {7'd0, v.exp_err});
    check($sformatf("%s done sel", name), bus.alu_Selector, 8'h00);
    @(posedge clk);
    #1;
    check($sformatf("%s idle done", name), {7'd0, bus.done}, 8'h00);
    bus.rd_sel = v.dst;
    #1;
    check($sformatf("%s R%0d", name, v.dst), bus.rd_data, e);
    check($sformatf("%s flags", name), bus.flags_q, v.exp_flags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    drive(mk(8'h00, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    bus.rd_sel = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {7'd0, bus.cmd_ready}, 8'h00);
    check("rst state", {6'd0, dbg_state}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst ready", {7'd0, bus.cmd_ready}, 8'h01);
    check("post-rst done", {7'd0, bus.done}, 8'h00);
    check("post-rst err", {7'd0, bus.err}, 8'h00);
    check("post-rst flags", bus.flags_q, 8'h00);
    check("post-rst sel", bus.alu_Selector, 8'h00);
    for (int r = 0; r < 4; r++) begin
      bus.rd_sel = r[1:0];
      #1;
      check($sformatf("post-rst R%0d", r), bus.rd_data, 8'h00);
    end

    //          op     dst   sa    sb    imm   immv   R[dst] flags  err
    vecs.push_back(mk(8'h80, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 8'h00, 1'b0)); // MOV R1<=7F
    vecs.push_back(mk(8'h01, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h80, 8'h44, 1'b0)); // ADD overflow
    vecs.push_back(mk(8'h80, 2'd1, 2'd0, 2'd0, 1'b1, 8'h07, 8'h07, 8'h00, 1'b0)); // MOV R1<=07
    vecs.push_back(mk(8'h01, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 8'h87, 8'h04, 1'b0)); // ADD reg+reg
    vecs.push_back(mk(8'h04, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 8'h87, 8'h04, 1'b1)); // DIV by 0
    vecs.push_back(mk(8'h80, 2'd0, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 8'h00, 1'b0)); // MOV R0<=05
    vecs.push_back(mk(8'h0F, 2'd2, 2'd0, 2'd0, 1'b1, 8'h05, 8'h80, 8'h01, 1'b0)); // CMP equal
    vecs.push_back(mk(8'h20, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03, 8'h07, 8'h01, 1'b1)); // bad op 20
    vecs.push_back(mk(8'h02, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0)); // SUB R1-R1
    vecs.push_back(mk(8'h01, 2'd1, 2'd1, 2'd0, 1'b1, 8'h09, 8'h09, 8'h00, 1'b0)); // sees new R1
    vecs.push_back(mk(8'h04, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00, 8'h0E, 8'h00, 1'b0)); // DIV 80/9
    vecs.push_back(mk(8'h05, 2'd3, 2'd3, 2'd0, 1'b1, 8'h10, 8'h07, 8'h00, 1'b0)); // REM 87%10
    vecs.push_back(mk(8'h05, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h0E, 8'h00, 1'b1)); // REM by 0
    vecs.push_back(mk(8'h00, 2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 8'h80, 8'h00, 1'b1)); // bad op 00
    vecs.push_back(mk(8'h10, 2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 8'h80, 8'h00, 1'b1)); // bad op 10
    vecs.push_back(mk(8'h81, 2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 8'h80, 8'h00, 1'b1)); // bad op 81
    vecs.push_back(mk(8'h0E, 2'd2, 2'd2, 2'd0, 1'b1, 8'hFF, 8'h7F, 8'h00, 1'b0)); // op 0E legal

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp_dst);
      run_cmd(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back commands with cmd_valid held: the second waits for IDLE.
    @(negedge clk);
    bus.rd_sel = 2'd2;
    drive(mk(8'h80, 2'd2, 2'd0, 2'd0, 1'b1, 8'h33, 8'h00, 8'h00, 1'b0));
    bus.cmd_valid = 1'b1;
    wait_ready("b2b first");
    @(posedge clk);
    #1;
    drive(mk(8'h01, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b0));
    check("b2b issue sel", bus.alu_Selector, 8'h80);
    check("b2b issue ready", {7'd0, bus.cmd_ready}, 8'h00);
    check("b2b old rd", bus.rd_data, 8'h7F);
    @(posedge clk);
    #1;
    check("b2b done ready", {7'd0, bus.cmd_ready}, 8'h00);
    check("b2b done sel", bus.alu_Selector, 8'h00);
    check("b2b new rd", bus.rd_data, 8'h33);
    @(posedge clk);
    #1;
    check("b2b idle ready", {7'd0, bus.cmd_ready}, 8'h01);
    check("b2b idle sel", bus.alu_Selector, 8'h00);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("b2b second sel", bus.alu_Selector, 8'h01);
    check("b2b second A", bus.alu_A, 8'h33);
    @(posedge clk);
    #1;
    check("b2b second done", {7'd0, bus.done}, 8'h01);
    @(posedge clk);
    #1;
    bus.rd_sel = 2'd3;
    #1;
    check("b2b R3", bus.rd_data, 8'h34);
    check("b2b flags", bus.flags_q, 8'h00);

    // Reset asserted during ISSUE of a SUB aborts it.
    @(negedge clk);
    drive(mk(8'h02, 2'd0, 2'd3, 2'd0, 1'b1, 8'h04, 8'h00, 8'h00, 1'b0));
    bus.cmd_valid = 1'b1;
    wait_ready("abort");
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("abort issue sel", bus.alu_Selector, 8'h02);
    rst = 1'b1;
    #1;
    check("abort ready", {7'd0, bus.cmd_ready}, 8'h00);
    check("abort state", {6'd0, dbg_state}, 8'h00);
    check("abort sel", bus.alu_Selector, 8'h00);
    check("abort A", bus.alu_A, 8'h00);
    check("abort B", bus.alu_B, 8'h00);
    check("abort flags", bus.flags_q, 8'h00);
    check("abort done", {7'd0, bus.done}, 8'h00);
    check("abort err", {7'd0, bus.err}, 8'h00);
    bus.rd_sel = 2'd0;
    #1;
    check("abort R0", bus.rd_data, 8'h00);
    bus.rd_sel = 2'd3;
    #1;
    check("abort R3", bus.rd_data, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort release ready", {7'd0, bus.cmd_ready}, 8'h01);
    exp_q.push_back(8'h22);
    run_cmd(mk(8'h01, 2'd1, 2'd0, 2'd0, 1'b1, 8'h22, 8'h22, 8'h00, 1'b0), "post-abort add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
